// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction fetch stage.
// Holds the NOP encoding shown to decode while nothing is buffered, the
// default reset PC, the fetch state enumeration and a word-align helper.
package if_stage_pkg;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    // RUN: fetch normally. DRAIN: swallow responses of requests issued
    // before a redirect, with new requests held off until they are gone.
    typedef enum logic [0:0] {
        FETCH_RUN   = 1'b0,
        FETCH_DRAIN = 1'b1
    } fetch_state_e;

    // Clear the byte-offset bits of a fetch target.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction memory bus between the fetch stage and instruction memory.
//   imem_req_valid / imem_req_ready / imem_req_addr : fetch request handshake
//   imem_resp_valid / imem_resp_data                : in-order response, no backpressure
// master = fetch stage side, slave = memory side.
interface if_stage_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );
endinterface

// File: rtl/if_stage_fetch_fifo.sv
// Fetch buffer: synchronous FIFO of {pc, inst} entries with a flush input.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   flush       : empty the FIFO this edge; overrides push and pop
//   push, wdata : write an entry (ignored when full unless popping too)
//   pop         : drop the head entry (ignored when empty)
//   rdata       : head entry, registered storage only
//   empty       : no entries held
//   count       : number of entries held
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             full_s;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_s    = (cnt_q == CW'(DEPTH));
    assign empty     = (cnt_q == {CW{1'b0}});
    assign do_pop_s  = pop & ~empty;
    // A full FIFO may still take a write when its head leaves the same cycle.
    assign do_push_s = push & (~full_s | do_pop_s);
    assign rdata     = mem_q[rd_ptr_q];
    assign count     = cnt_q;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            cnt_d    = {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // FIFO state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            cnt_q    <= {CW{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage.
// Issues word-aligned fetches from a running PC, buffers in-order responses
// with their PCs in fetch_fifo and presents the head to decode. A redirect
// flushes the buffer, reloads the PC and discards every response still in
// flight (DRAIN) before normal fetching resumes (RUN).
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   imem            : instruction memory bus (master side)
//   redirect_valid  : taken branch / jal / jalr from execute
//   redirect_pc     : new fetch target (low two bits ignored)
//   inst_valid      : buffer head holds an instruction
//   inst_ready      : decode consumes the head this cycle
//   inst, inst_pc   : head instruction and its PC (NOP / 0 when empty)
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          BUF_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    if_stage_if.master    imem,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    output logic          inst_valid,
    input  logic          inst_ready,
    output logic [31:0]   inst,
    output logic [31:0]   inst_pc
);

    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int BW = CW + 1;

    fetch_state_e  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] discard_q, discard_d;

    logic          fifo_empty_s;
    logic [CW-1:0] fifo_count_s;
    logic [63:0]   fifo_rdata_s;
    logic          pop_s;
    logic          push_s;
    logic          req_valid_s;
    logic          req_fire_s;
    logic [BW-1:0] budget_s;

    assign pop_s = ~fifo_empty_s & inst_ready;

    // The entry leaving this cycle frees its slot for a new request, which
    // keeps a full-rate stream when decode consumes every cycle. Requests are
    // held off during reset so imem sees no request while rst_n is low.
    assign budget_s    = BW'(outst_q) + BW'(fifo_count_s) - BW'(pop_s);
    assign req_valid_s = rst_n & (state_q == FETCH_RUN) & (budget_s < BW'(BUF_DEPTH));
    assign req_fire_s  = req_valid_s & imem.imem_req_ready;

    // Only responses of live requests are buffered; a redirect in the same
    // cycle flushes the FIFO, which also drops this cycle's push.
    assign push_s = imem.imem_resp_valid & (state_q == FETCH_RUN);

    assign imem.imem_req_valid = req_valid_s;
    assign imem.imem_req_addr  = pc_q;

    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid),
        .push  (push_s),
        .wdata ({resp_pc_q, imem.imem_resp_data}),
        .pop   (pop_s),
        .rdata (fifo_rdata_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    assign inst_valid = ~fifo_empty_s;
    assign inst       = fifo_empty_s ? NOP_INST : fifo_rdata_s[31:0];
    assign inst_pc    = fifo_empty_s ? 32'h0000_0000 : fifo_rdata_s[63:32];

    // Next-state: fetch PC, response PC tag, in-flight count and drain FSM.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        resp_pc_d = resp_pc_q;
        outst_d   = outst_q;
        discard_d = discard_q;

        case ({req_fire_s, imem.imem_resp_valid})
            2'b10:   outst_d = outst_q + CW'(1);
            2'b01:   outst_d = outst_q - CW'(1);
            default: outst_d = outst_q;
        endcase

        if (redirect_valid) begin
            // Everything still in flight after this edge, including a request
            // accepted this very cycle, belongs to the abandoned path.
            pc_d      = align_word(redirect_pc);
            resp_pc_d = align_word(redirect_pc);
            discard_d = outst_d;
            state_d   = (outst_d != {CW{1'b0}}) ? FETCH_DRAIN : FETCH_RUN;
        end else begin
            if (req_fire_s) begin
                pc_d = pc_q + 32'd4;
            end else begin
                pc_d = pc_q;
            end
            case (state_q)
                FETCH_RUN: begin
                    if (imem.imem_resp_valid) begin
                        resp_pc_d = resp_pc_q + 32'd4;
                    end else begin
                        resp_pc_d = resp_pc_q;
                    end
                end
                FETCH_DRAIN: begin
                    if (imem.imem_resp_valid) begin
                        discard_d = discard_q - CW'(1);
                        state_d   = (discard_q == CW'(1)) ? FETCH_RUN : FETCH_DRAIN;
                    end else begin
                        discard_d = discard_q;
                        state_d   = FETCH_DRAIN;
                    end
                end
                default: begin
                    state_d = FETCH_RUN;
                end
            endcase
        end
    end

    // Fetch-stage state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH_RUN;
            pc_q      <= RESET_PC;
            resp_pc_q <= RESET_PC;
            outst_q   <= {CW{1'b0}};
            discard_q <= {CW{1'b0}};
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            resp_pc_q <= resp_pc_d;
            outst_q   <= outst_d;
            discard_q <= discard_d;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
    import if_stage_pkg::*;

    localparam int          BUF_DEPTH = 4;
    localparam logic [31:0] RST_PC    = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    if_stage_if bus();

    if_stage #(.RESET_PC(RST_PC), .BUF_DEPTH(BUF_DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem           (bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc)
    );

    always #5 clk = ~clk;

    // memory model: in-order pending requests
    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } mreq_t;
    mreq_t mq[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int lat_min = 1;
    int lat_max = 1;
    int fires = 0;
    int pops = 0;

    // reference model of the fetch stream
    logic [31:0] exp_req_pc;
    logic [31:0] exp_inst_pc;
    int          live;
    bit          redir_prev;

    // observations of the last step
    bit          o_rvalid, o_ivalid, did_redir;
    logic [31:0] o_raddr, o_ipc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'hC3A5_1E0F;
    endfunction

    task automatic model_reset();
        mq.delete();
        exp_req_pc  = RST_PC;
        exp_inst_pc = RST_PC;
        live        = 0;
        redir_prev  = 1'b0;
    endtask

    task automatic step(input bit rdy, input bit irdy, input bit redir,
                        input logic [31:0] tgt, input bit redir_on_both);
        bit fire, pop, rd, any_stale;
        logic [31:0] faddr;
        @(negedge clk);
        bus.imem_req_ready = rdy;
        inst_ready         = irdy;
        redirect_valid     = redir;
        redirect_pc        = tgt;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = mem_word(mq[0].addr);
        end else begin
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_data  = $urandom;
        end
        #1;
        fire  = bus.imem_req_valid & rdy;
        pop   = inst_valid & irdy;
        faddr = bus.imem_req_addr;
        if (redir_on_both && fire && pop) redirect_valid = 1'b1;
        rd = redirect_valid;
        did_redir = rd;
        #1;
        o_rvalid = bus.imem_req_valid;
        o_raddr  = bus.imem_req_addr;
        o_ivalid = inst_valid;
        o_ipc    = inst_pc;
        if (redir_prev) begin
            vectors++;
            if (inst_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL flush_valid: inst_valid=%b required 0", inst_valid);
            end
        end
        if (bus.imem_req_valid) begin
            vectors++;
            if (bus.imem_req_addr !== exp_req_pc) begin
                miscompares++;
                $display("FAIL req_addr: got %h required %h", bus.imem_req_addr, exp_req_pc);
            end
            vectors++;
            if (live - int'(pop) >= BUF_DEPTH) begin
                miscompares++;
                $display("FAIL req_credit: %0d held required < %0d", live - int'(pop), BUF_DEPTH);
            end
            any_stale = 1'b0;
            foreach (mq[i]) if (mq[i].stale) any_stale = 1'b1;
            vectors++;
            if (any_stale) begin
                miscompares++;
                $display("FAIL req_in_drain: request with stale responses pending=%b required 0", any_stale);
            end
        end
        if (pop) begin
            pops++;
            vectors++;
            if (inst_pc !== exp_inst_pc) begin
                miscompares++;
                $display("FAIL inst_pc: got %h required %h", inst_pc, exp_inst_pc);
            end
            vectors++;
            if (inst !== mem_word(exp_inst_pc)) begin
                miscompares++;
                $display("FAIL inst_word: got %h required %h", inst, mem_word(exp_inst_pc));
            end
        end
        @(posedge clk);
        if (bus.imem_resp_valid) void'(mq.pop_front());
        if (fire) begin
            mq.push_back('{addr: faddr, due: cyc + $urandom_range(lat_min, lat_max), stale: 1'b0});
            fires++;
            live++;
            exp_req_pc = exp_req_pc + 32'd4;
        end
        if (pop) begin
            live--;
            exp_inst_pc = exp_inst_pc + 32'd4;
        end
        if (rd) begin
            foreach (mq[i]) mq[i].stale = 1'b1;
            live        = 0;
            exp_req_pc  = {redirect_pc[31:2], 2'b00};
            exp_inst_pc = {redirect_pc[31:2], 2'b00};
        end
        redir_prev = rd;
        cyc++;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL rst_inst_valid: got %b required 0", inst_valid); end
        vectors++;
        if (bus.imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL rst_req_valid: got %b required 0", bus.imem_req_valid); end
        vectors++;
        if (bus.imem_req_addr !== RST_PC) begin miscompares++; $display("FAIL rst_req_addr: got %h required %h", bus.imem_req_addr, RST_PC); end
        vectors++;
        if (inst !== 32'h0000_0013) begin miscompares++; $display("FAIL rst_inst: got %h required 00000013", inst); end
        vectors++;
        if (inst_pc !== 32'h0) begin miscompares++; $display("FAIL rst_inst_pc: got %h required 0", inst_pc); end
        repeat (2) @(negedge clk);
        vectors++;
        if (dut.state_q !== FETCH_RUN) begin miscompares++; $display("FAIL rst_state: got %0d required RUN", dut.state_q); end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        // first request in the first cycle after release
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        vectors++;
        if (!(o_rvalid === 1'b1 && o_raddr === RST_PC)) begin
            miscompares++;
            $display("FAIL first_req: valid=%b addr=%h required 1 %h", o_rvalid, o_raddr, RST_PC);
        end
    endtask

    task automatic test_stream();
        int n;
        lat_min = 1; lat_max = 1;
        test_reset();
        n = 0;
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        while (!o_ivalid && n < 10) begin step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0); n++; end
        vectors++;
        if (o_ipc !== 32'h8000_0000) begin miscompares++; $display("FAIL stream_0: got %h required 80000000", o_ipc); end
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        vectors++;
        if (!(o_ivalid && o_ipc === 32'h8000_0004)) begin miscompares++; $display("FAIL stream_1: valid=%b pc=%h required 1 80000004", o_ivalid, o_ipc); end
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        vectors++;
        if (!(o_ivalid && o_ipc === 32'h8000_0008)) begin miscompares++; $display("FAIL stream_2: valid=%b pc=%h required 1 80000008", o_ivalid, o_ipc); end
    endtask

    task automatic test_backpressure();
        int p0;
        lat_min = 1; lat_max = 1;
        test_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        vectors++;
        if (o_rvalid !== 1'b0) begin miscompares++; $display("FAIL stall_req: req_valid=%b required 0", o_rvalid); end
        vectors++;
        if (live != BUF_DEPTH) begin miscompares++; $display("FAIL stall_held: %0d accepted required %0d", live, BUF_DEPTH); end
        p0 = pops;
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        vectors++;
        if (pops - p0 < 15) begin miscompares++; $display("FAIL stall_release: %0d delivered required >= 15", pops - p0); end
    endtask

    task automatic test_redirect_drain();
        int n;
        lat_min = 5; lat_max = 5;
        test_reset();
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 32'h8000_0100, 1'b0);
        #1;
        vectors++;
        if (dut.state_q !== FETCH_DRAIN) begin miscompares++; $display("FAIL drain_enter: state=%0d required DRAIN", dut.state_q); end
        n = 0;
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        while (!o_ivalid && n < 40) begin step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0); n++; end
        vectors++;
        if (!(o_ivalid && o_ipc === 32'h8000_0100)) begin miscompares++; $display("FAIL drain_target: valid=%b pc=%h required 1 80000100", o_ivalid, o_ipc); end
        #1;
        vectors++;
        if (dut.state_q !== FETCH_RUN) begin miscompares++; $display("FAIL drain_exit: state=%0d required RUN", dut.state_q); end
    endtask

    task automatic test_redirect_collision();
        int n;
        lat_min = 1; lat_max = 1;
        test_reset();
        n = 0;
        did_redir = 1'b0;
        while (!did_redir && n < 20) begin step(1'b1, 1'b1, 1'b0, 32'h8000_0400, 1'b1); n++; end
        vectors++;
        if (!did_redir) begin miscompares++; $display("FAIL collide_setup: no cycle with request and pop in %0d", n); end
        n = 0;
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        while (!o_ivalid && n < 20) begin step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0); n++; end
        vectors++;
        if (!(o_ivalid && o_ipc === 32'h8000_0400)) begin miscompares++; $display("FAIL collide_target: valid=%b pc=%h required 1 80000400", o_ivalid, o_ipc); end
    endtask

    task automatic test_align_and_wrap();
        int n;
        bit seen;
        lat_min = 1; lat_max = 2;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 32'h8000_0202, 1'b0);
        n = 0;
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        while (!o_rvalid && n < 20) begin step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0); n++; end
        vectors++;
        if (!(o_rvalid && o_raddr === 32'h8000_0200)) begin miscompares++; $display("FAIL align_addr: valid=%b addr=%h required 1 80000200", o_rvalid, o_raddr); end
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
            if (o_ivalid && o_ipc === 32'h0000_0000) seen = 1'b1;
        end
        vectors++;
        if (!seen) begin miscompares++; $display("FAIL pc_wrap: pc 00000000 delivered=%b required 1", seen); end
    endtask

    task automatic test_reset_midflight();
        int f0, n;
        lat_min = 1; lat_max = 1;
        test_reset();
        // first call of test_reset already accepted one request
        f0 = fires;
        n = 0;
        while (fires - f0 < 2 && n < 10) begin step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0); n++; end
        lat_min = 30; lat_max = 30;
        n = 0;
        while (fires - f0 < 3 && n < 10) begin step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0); n++; end
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        vectors++;
        if (!(o_ivalid === 1'b1 && mq.size() == 1)) begin
            miscompares++;
            $display("FAIL midflight_setup: inst_valid=%b pending=%0d required 1 1", o_ivalid, mq.size());
        end
        lat_min = 1; lat_max = 1;
        test_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_random();
        int p0;
        bit rd;
        logic [31:0] tgt;
        lat_min = 1; lat_max = 4;
        test_reset();
        p0 = pops;
        for (int i = 0; i < 800; i++) begin
            rd  = ($urandom_range(0, 29) == 0);
            tgt = 32'h8000_0000 | ($urandom & 32'h0000_0FFF);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, rd, tgt, 1'b0);
        end
        vectors++;
        if (pops - p0 < 100) begin miscompares++; $display("FAIL random_progress: %0d delivered required >= 100", pops - p0); end
    endtask

    initial begin
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
        model_reset();
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drain();
        test_redirect_collision();
        test_align_and_wrap();
        test_reset_midflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
